// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared constants and FSM state type for the MDIO peripheral
package mdio_pkg;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] ST_END    = 5'd1;
  localparam logic [CNT_W-1:0] OP_END    = 5'd3;
  localparam logic [CNT_W-1:0] REGAD_END = 5'd13;
  localparam logic [CNT_W-1:0] TA_END    = 5'd15;
  localparam logic [CNT_W-1:0] DATA_END  = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_WRITE,
    S_READ,
    S_ABORT
  } mdio_state_e;

endpackage

// File: rtl/mdio_shift16.sv
// rtl/mdio_shift16.sv - 16-bit left shift register with parallel load
// Serial input enters at bit 0; bit 15 of q_o is the serial output.
module mdio_shift16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] data_i,
  input  logic        shift_i,
  input  logic        sin_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= data_i;
    end else if (shift_i) begin
      q_q <= {q_q[14:0], sin_i};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mdio_peripheral.sv
// rtl/mdio_peripheral.sv - MDIO Clause 22 PHY-side frame decoder and read-back serialiser
module mdio_peripheral
  import mdio_pkg::*;
(
  input  logic        MDC,
  input  logic        RESET,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  input  logic [15:0] RD_DATA,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        MDIO_DONE,
  output logic        MDIO_IN
);

  mdio_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       addr_q, addr_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic             wr_stb_q, wr_stb_d;
  logic             done_q, done_d;
  logic             mdio_in_q, mdio_in_d;
  logic             sh_load, sh_shift;
  logic [15:0]      sh_q;
  logic [1:0]       pair;

  // Read data is preloaded one bit ahead so bit 15 of the shifter is always the next bit out.
  mdio_shift16 u_shift (
    .clk_i   (MDC),
    .rst_i   (RESET),
    .load_i  (sh_load),
    .data_i  ({RD_DATA[14:0], 1'b0}),
    .shift_i (sh_shift),
    .sin_i   (MDIO_OUT),
    .q_o     (sh_q)
  );

  assign pair = {sh_q[0], MDIO_OUT};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_stb_d  = 1'b0;
    done_d    = 1'b0;
    mdio_in_d = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (MDIO_OE) begin
          state_d  = S_HEADER;
          cnt_d    = CNT_W'(1);
          sh_shift = 1'b1;
        end
      end
      S_HEADER: begin
        sh_shift = 1'b1;
        if (cnt_q == ST_END && pair != ST_CODE) begin
          state_d = S_ABORT;
        end
        if (cnt_q == OP_END && pair != OP_WRITE && pair != OP_READ) begin
          state_d = S_ABORT;
        end
        if (cnt_q == REGAD_END) begin
          addr_d = {sh_q[3:0], MDIO_OUT};
        end
        // OP sits at shifter bits 12:11 once bits 0..14 have been captured.
        if (cnt_q == TA_END) begin
          if (sh_q[12:11] == OP_WRITE) begin
            state_d = S_WRITE;
          end else begin
            state_d   = S_READ;
            sh_shift  = 1'b0;
            sh_load   = 1'b1;
            mdio_in_d = RD_DATA[15];
          end
        end
      end
      S_WRITE: begin
        if (!MDIO_OE) begin
          state_d = S_ABORT;
        end else begin
          sh_shift = 1'b1;
          if (cnt_q == DATA_END) begin
            wr_data_d = {sh_q[14:0], MDIO_OUT};
            wr_stb_d  = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_READ: begin
        if (cnt_q == DATA_END) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          sh_shift  = 1'b1;
          mdio_in_d = sh_q[15];
        end
      end
      S_ABORT: begin
        cnt_d = '0;
        if (!MDIO_OE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge MDC) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_stb_q  <= 1'b0;
      done_q    <= 1'b0;
      mdio_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_stb_q  <= wr_stb_d;
      done_q    <= done_d;
      mdio_in_q <= mdio_in_d;
    end
  end

  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;
  assign WR_STB    = wr_stb_q;
  assign MDIO_DONE = done_q;
  assign MDIO_IN   = mdio_in_q;

endmodule

// File: tb/tb_mdio_peripheral.sv
// tb/tb_mdio_peripheral.sv - directed self-checking bench with controller model and register memory
module tb_mdio_peripheral;

  logic        mdc = 1'b0;
  logic        reset;
  logic        mdio_oe;
  logic        mdio_out;
  logic [15:0] rd_data;
  logic [4:0]  addr;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        mdio_done;
  logic        mdio_in;

  int checks   = 0;
  int failures = 0;
  int stb_cnt  = 0;
  int done_cnt = 0;
  logic        preload;
  logic [15:0] mem [32];

  mdio_peripheral dut (
    .MDC       (mdc),
    .RESET     (reset),
    .MDIO_OE   (mdio_oe),
    .MDIO_OUT  (mdio_out),
    .RD_DATA   (rd_data),
    .ADDR      (addr),
    .WR_DATA   (wr_data),
    .WR_STB    (wr_stb),
    .MDIO_DONE (mdio_done),
    .MDIO_IN   (mdio_in)
  );

  always #5 mdc = ~mdc;

  // Register file side of the peripheral_tester model.
  always @(posedge mdc) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[16] <= 16'h1234;
    end else if (wr_stb) begin
      mem[addr] <= wr_data;
    end
  end

  always_comb rd_data = mem[addr];

  always @(negedge mdc) begin
    if (wr_stb)    stb_cnt++;
    if (mdio_done) done_cnt++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_frame(input logic [1:0] st, input logic [1:0] op,
                                           input logic [4:0] regad, input logic [15:0] data);
    return {st, op, 5'd0, regad, 2'b10, data};
  endfunction

  // Drives bits 0..nbits-1 of f (OE high for bits below oe_bits), capturing MDIO_IN after edges 15..30.
  task automatic run_frame(input logic [31:0] f, input int oe_bits, input int nbits,
                           output logic [15:0] rd);
    rd = '0;
    for (int n = 0; n < nbits; n++) begin
      @(negedge mdc);
      if (n >= 16) rd = {rd[14:0], mdio_in};
      mdio_oe  = (n < oe_bits);
      mdio_out = f[31-n];
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge mdc);
      mdio_oe  = 1'b0;
      mdio_out = 1'b0;
    end
  endtask

  task automatic finish_frame(input string tag, input logic exp_stb);
    @(negedge mdc);
    chk_eq({tag, "_stb"}, wr_stb, exp_stb);
    chk_eq({tag, "_done"}, mdio_done, 1'b1);
    chk_eq({tag, "_mdio_in_end"}, mdio_in, 1'b0);
    mdio_oe  = 1'b0;
    mdio_out = 1'b0;
    @(negedge mdc);
    chk_eq({tag, "_stb_1cyc"}, wr_stb, 1'b0);
    chk_eq({tag, "_done_1cyc"}, mdio_done, 1'b0);
  endtask

  initial begin
    logic [15:0] rd;
    int s0, d0;
    reset    = 1'b1;
    preload  = 1'b1;
    mdio_oe  = 1'b0;
    mdio_out = 1'b0;
    repeat (2) @(negedge mdc);
    chk_eq("rst_addr", addr, 0);
    chk_eq("rst_wr_data", wr_data, 0);
    chk_eq("rst_stb", wr_stb, 0);
    chk_eq("rst_done", mdio_done, 0);
    chk_eq("rst_mdio_in", mdio_in, 0);
    reset   = 1'b0;
    preload = 1'b0;
    idle(4);
    chk_eq("idle_done", done_cnt, 0);
    chk_eq("idle_wr_data", wr_data, 0);

    run_frame(mk_frame(2'b01, 2'b01, 5'h10, 16'hABCD), 32, 32, rd);
    finish_frame("wr10", 1'b1);
    chk_eq("wr10_addr", addr, 5'h10);
    chk_eq("wr10_data", wr_data, 16'hABCD);
    idle(2);

    // Restore the read target so the read checks an independent pattern.
    @(negedge mdc);
    preload = 1'b1;
    @(negedge mdc);
    preload = 1'b0;
    s0 = stb_cnt;
    run_frame(mk_frame(2'b01, 2'b10, 5'h10, 16'h0000), 16, 32, rd);
    finish_frame("rd10", 1'b0);
    chk_eq("rd10_data", rd, 16'h1234);
    chk_eq("rd10_no_stb", stb_cnt - s0, 0);
    chk_eq("rd10_wr_data_held", wr_data, 16'hABCD);
    idle(2);

    s0 = stb_cnt;
    d0 = done_cnt;
    run_frame(mk_frame(2'b00, 2'b01, 5'h07, 16'h1111), 32, 32, rd);
    idle(3);
    chk_eq("bad_st_stb", stb_cnt - s0, 0);
    chk_eq("bad_st_done", done_cnt - d0, 0);
    chk_eq("bad_st_wr_data", wr_data, 16'hABCD);
    chk_eq("bad_st_addr", addr, 5'h10);
    run_frame(mk_frame(2'b01, 2'b11, 5'h07, 16'h2222), 32, 32, rd);
    idle(3);
    chk_eq("bad_op_stb", stb_cnt - s0, 0);
    chk_eq("bad_op_done", done_cnt - d0, 0);
    chk_eq("bad_op_wr_data", wr_data, 16'hABCD);
    run_frame(mk_frame(2'b01, 2'b01, 5'h05, 16'hBEEF), 32, 32, rd);
    finish_frame("wr05", 1'b1);
    chk_eq("wr05_addr", addr, 5'h05);
    chk_eq("wr05_data", wr_data, 16'hBEEF);
    idle(2);

    s0 = stb_cnt;
    d0 = done_cnt;
    run_frame(mk_frame(2'b01, 2'b01, 5'h0A, 16'h5555), 32, 20, rd);
    @(negedge mdc);
    reset    = 1'b1;
    mdio_oe  = 1'b1;
    mdio_out = 1'b1;
    @(negedge mdc);
    chk_eq("midrst_addr", addr, 0);
    chk_eq("midrst_wr_data", wr_data, 0);
    chk_eq("midrst_stb", wr_stb, 0);
    chk_eq("midrst_done", mdio_done, 0);
    chk_eq("midrst_mdio_in", mdio_in, 0);
    reset = 1'b0;
    idle(3);
    chk_eq("midrst_no_stb", stb_cnt - s0, 0);
    chk_eq("midrst_no_done", done_cnt - d0, 0);
    run_frame(mk_frame(2'b01, 2'b01, 5'h0A, 16'h5555), 32, 32, rd);
    finish_frame("wr0a", 1'b1);
    chk_eq("wr0a_addr", addr, 5'h0A);
    chk_eq("wr0a_data", wr_data, 16'h5555);
    idle(2);

    s0 = stb_cnt;
    d0 = done_cnt;
    run_frame(mk_frame(2'b01, 2'b01, 5'h1F, 16'hFFFF), 32, 32, rd);
    run_frame(mk_frame(2'b01, 2'b10, 5'h1F, 16'h0000), 16, 32, rd);
    finish_frame("b2b", 1'b0);
    idle(2);
    chk_eq("b2b_readback", rd, 16'hFFFF);
    chk_eq("b2b_done_pulses", done_cnt - d0, 2);
    chk_eq("b2b_stb_pulses", stb_cnt - s0, 1);
    chk_eq("b2b_wr_data", wr_data, 16'hFFFF);
    chk_eq("b2b_addr", addr, 5'h1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
